ahb3lite_burst_arbiter: RTL and testbench

AHB3LITE_BURST_ARBITER -- requirements
Module: ahb3lite_burst_arbiter

---
 rtl/ahb3lite_burst_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_ahb3lite_burst_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_burst_arbiter.sv
// ---------------------------------------------------------------------------
// ahb3lite_burst_arbiter
//
// Purpose:
//   Arbitrates ownership of one AHB3-Lite slave among MASTERS requesters.
//   Ownership only moves at legal switch points of the current owner's
//   transfer stream: IDLE, a SINGLE NONSEQ, the last beat of a fixed-length
//   burst, or an undefined-length INCR that has held the bus for MAX_HOLD
//   cycles while someone else was waiting. Locked sequences are never broken.
//   Among requesters the highest mstpriority level wins. Ties within a level
//   are broken round-robin, and each level keeps its own last-grant pointer.
//
// Parameters:
//   MASTERS   number of requesting masters (2..16)
//   MAX_HOLD  owner cycles with another master waiting before the fairness
//             release applies to undefined-length INCR (1..255)
//
// Ports:
//   HCLK            clock, all state changes on the rising edge
//   HRESETn         asynchronous active-low reset
//   req             per-master request (that master's HSEL for this slave)
//   mstpriority     per-master 3-bit priority, 7 is highest
//   own_HTRANS      HTRANS driven by the current owner
//   own_HBURST      HBURST driven by the current owner
//   own_HMASTLOCK   HMASTLOCK driven by the current owner
//   HREADY          slave-side HREADY, qualifies every transfer advance
//   granted_master  one-hot current owner
//   granted_idx     binary index of the current owner
//   can_switch      combinational: this cycle is a legal switch point
//   hold_expired    owner has held MAX_HOLD cycles while others requested
//   arb_state       observable arbiter state: 0 IDLE, 1 OWNED, 2 BURST,
//                   3 LOCKED
// ---------------------------------------------------------------------------
module ahb3lite_burst_arbiter #(
  parameter int MASTERS  = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [MASTERS-1:0]         req,
  input  logic [MASTERS-1:0][2:0]    mstpriority,
  input  logic [1:0]                 own_HTRANS,
  input  logic [2:0]                 own_HBURST,
  input  logic                       own_HMASTLOCK,
  input  logic                       HREADY,
  output logic [MASTERS-1:0]         granted_master,
  output logic [$clog2(MASTERS)-1:0] granted_idx,
  output logic                       can_switch,
  output logic                       hold_expired,
  output logic [1:0]                 arb_state
);

  localparam int         IDX_W    = $clog2(MASTERS);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  // HTRANS encodings
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  // HBURST encodings
  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [2:0] HB_WRAP4  = 3'b010;
  localparam logic [2:0] HB_INCR4  = 3'b011;
  localparam logic [2:0] HB_WRAP8  = 3'b100;
  localparam logic [2:0] HB_INCR8  = 3'b101;
  localparam logic [2:0] HB_WRAP16 = 3'b110;
  localparam logic [2:0] HB_INCR16 = 3'b111;

  localparam logic [MASTERS-1:0] MASTER0_OH = {{(MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_BURST  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Beats remaining after the NONSEQ of a fixed-length burst.
  function automatic logic [3:0] f_burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      HB_WRAP4,  HB_INCR4:  beats = 4'd3;
      HB_WRAP8,  HB_INCR8:  beats = 4'd7;
      HB_WRAP16, HB_INCR16: beats = 4'd15;
      default:              beats = 4'd0;
    endcase
    return beats;
  endfunction

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t             r_state;
  logic [3:0]         r_beats_left;
  logic [7:0]         r_hold;
  logic [MASTERS-1:0] r_granted;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [MASTERS-1:0] r_last_grant [8];

  // ---------------------------------------------------------------------
  // Combinational nets
  // ---------------------------------------------------------------------
  logic               w_hold_expired;
  logic               w_sw_idle;
  logic               w_sw_single;
  logic               w_sw_last;
  logic               w_sw_fair;
  logic [3:0]         w_beats_nxt;
  logic [2:0]         w_level;
  logic [MASTERS-1:0] w_cand;
  logic [MASTERS-1:0] w_cand_others;
  logic [MASTERS-1:0] w_cand_final;
  logic [MASTERS-1:0] w_last_oh;
  logic [IDX_W-1:0]   w_last_idx;
  logic [IDX_W-1:0]   w_scan;
  logic               w_found;
  logic [IDX_W-1:0]   w_win_idx;
  logic [MASTERS-1:0] w_win_oh;
  logic               w_any_req;
  logic               w_other_req;
  logic               w_take;
  logic               w_grant_change;

  assign w_hold_expired = (r_hold == HOLD_MAX);
  assign w_any_req      = |req;
  assign w_other_req    = |(req & ~r_granted);

  // Legal switch points. Any asserted lock overrides all of them, including
  // the fairness release.
  assign w_sw_idle   = (own_HTRANS == TR_IDLE);
  assign w_sw_single = (own_HTRANS == TR_NONSEQ) && (own_HBURST == HB_SINGLE);
  assign w_sw_last   = (own_HTRANS == TR_SEQ) && (r_beats_left == 4'd1);
  assign w_sw_fair   = (own_HBURST == HB_INCR) && w_hold_expired &&
                       (own_HTRANS != TR_BUSY);
  assign can_switch  = HREADY && !own_HMASTLOCK &&
                       (w_sw_idle || w_sw_single || w_sw_last || w_sw_fair);

  // Burst beat counter: loaded on NONSEQ, decremented on SEQ, and held on
  // BUSY, IDLE and wait states. It saturates at zero.
  always_comb begin
    w_beats_nxt = r_beats_left;
    if (HREADY) begin
      if (own_HTRANS == TR_NONSEQ) begin
        w_beats_nxt = f_burst_beats(own_HBURST);
      end else if ((own_HTRANS == TR_SEQ) && (r_beats_left != 4'd0)) begin
        w_beats_nxt = r_beats_left - 4'd1;
      end
    end
  end

  // Highest requested priority level and the requesters sitting on it.
  always_comb begin
    w_level = 3'd0;
    for (int i = 0; i < MASTERS; i++) begin
      if (req[i] && (mstpriority[i] > w_level)) begin
        w_level = mstpriority[i];
      end
    end
    w_cand = '0;
    for (int i = 0; i < MASTERS; i++) begin
      w_cand[i] = req[i] && (mstpriority[i] == w_level);
    end
  end

  // Once the hold limit is reached the owner steps aside, but only if some
  // other master at the winning level can take over. Otherwise it keeps the
  // bus and its hold count.
  assign w_cand_others = w_cand & ~r_granted;
  assign w_cand_final  = (w_hold_expired && (|w_cand_others)) ? w_cand_others
                                                              : w_cand;

  // Round-robin within the level, starting at the index after that level's
  // last grant.
  always_comb begin
    w_last_oh  = r_last_grant[w_level];
    w_last_idx = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (w_last_oh[i]) begin
        w_last_idx = IDX_W'(i);
      end
    end
    w_scan    = w_last_idx;
    w_found   = 1'b0;
    w_win_idx = r_grant_idx;
    for (int i = 0; i < MASTERS; i++) begin
      w_scan = (w_scan == IDX_W'(MASTERS - 1)) ? '0 : w_scan + IDX_W'(1);
      if (!w_found && w_cand_final[w_scan]) begin
        w_found   = 1'b1;
        w_win_idx = w_scan;
      end
    end
    w_win_oh            = '0;
    w_win_oh[w_win_idx] = 1'b1;
  end

  // With no requester the grant parks on the current owner.
  assign w_take         = can_switch && w_any_req;
  assign w_grant_change = w_take && (w_win_idx != r_grant_idx);

  // ---------------------------------------------------------------------
  // Grant, round-robin pointers, hold counter and beat counter
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_granted    <= MASTER0_OH;
      r_grant_idx  <= '0;
      r_hold       <= 8'd0;
      r_beats_left <= 4'd0;
      for (int l = 0; l < 8; l++) begin
        r_last_grant[l] <= MASTER0_OH;
      end
    end else begin
      r_beats_left <= w_beats_nxt;
      if (w_take) begin
        r_granted              <= w_win_oh;
        r_grant_idx            <= w_win_idx;
        r_last_grant[w_level]  <= w_win_oh;
      end
      // An owner that wins again by round-robin keeps counting, because its
      // grant did not change.
      if (w_grant_change || !w_other_req) begin
        r_hold <= 8'd0;
      end else if (r_hold != HOLD_MAX) begin
        r_hold <= r_hold + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Arbiter state, updated on transfer-advancing edges only
  // ---------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else if (HREADY) begin
      if (own_HMASTLOCK) begin
        r_state <= ST_LOCKED;
      end else if (w_beats_nxt != 4'd0) begin
        r_state <= ST_BURST;
      end else if (w_any_req) begin
        r_state <= ST_OWNED;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign granted_master = r_granted;
  assign granted_idx    = r_grant_idx;
  assign hold_expired   = w_hold_expired;
  assign arb_state      = r_state;

endmodule

// File: tb/tb_ahb3lite_burst_arbiter.sv
`timescale 1ns/1ps
module tb_ahb3lite_burst_arbiter;

  localparam int M  = 3;
  localparam int MH = 4;

  logic               HCLK;
  logic               HRESETn;
  logic [M-1:0]       req;
  logic [M-1:0][2:0]  prio;
  logic [1:0]         htrans;
  logic [2:0]         hburst;
  logic               lock;
  logic               hready;
  logic [M-1:0]       granted_master;
  logic [1:0]         granted_idx;
  logic               can_switch;
  logic               hold_expired;
  logic [1:0]         arb_state;

  ahb3lite_burst_arbiter #(.MASTERS(M), .MAX_HOLD(MH)) dut (
    .HCLK           (HCLK),
    .HRESETn        (HRESETn),
    .req            (req),
    .mstpriority    (prio),
    .own_HTRANS     (htrans),
    .own_HBURST     (hburst),
    .own_HMASTLOCK  (lock),
    .HREADY         (hready),
    .granted_master (granted_master),
    .granted_idx    (granted_idx),
    .can_switch     (can_switch),
    .hold_expired   (hold_expired),
    .arb_state      (arb_state)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3,
                         B_INCR8 = 3'd5, B_WRAP16 = 3'd6;

  typedef struct {
    logic [M-1:0] gm;
    logic [1:0]   gi;
    logic         cs;
    logic         he;
    logic [1:0]   st;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Reference model state
  int m_owner;
  int m_beats;
  int m_hold;
  int m_state;
  int m_last[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_beats = 0;
    m_hold  = 0;
    m_state = 0;
    for (int l = 0; l < 8; l++) m_last[l] = 0;
  endtask

  function automatic int burst_len(input logic [2:0] hb);
    case (hb)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic bit m_hold_exp();
    return m_hold == MH;
  endfunction

  function automatic bit m_can_switch();
    if (!hready || lock) return 1'b0;
    if (htrans == T_IDLE) return 1'b1;
    if (htrans == T_NSEQ && hburst == B_SINGLE) return 1'b1;
    if (htrans == T_SEQ && m_beats == 1) return 1'b1;
    if (hburst == B_INCR && m_hold_exp() && htrans != T_BUSY) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model across one rising edge using the inputs present there.
  task automatic model_edge();
    bit cs;
    bit others;
    bit cand_other;
    bit cand[M];
    int lvl;
    int win;
    cs = m_can_switch();
    others = 1'b0;
    for (int i = 0; i < M; i++) if (req[i] && i != m_owner) others = 1'b1;
    win = m_owner;
    if (cs && req != '0) begin
      lvl = -1;
      for (int i = 0; i < M; i++) if (req[i] && int'(prio[i]) > lvl) lvl = int'(prio[i]);
      cand_other = 1'b0;
      for (int i = 0; i < M; i++) begin
        cand[i] = req[i] && (int'(prio[i]) == lvl);
        if (cand[i] && i != m_owner) cand_other = 1'b1;
      end
      if (m_hold_exp() && cand_other) cand[m_owner] = 1'b0;
      for (int k = 1; k <= M; k++) begin
        int j;
        j = (m_last[lvl] + k) % M;
        if (cand[j]) begin
          win = j;
          break;
        end
      end
      m_last[lvl] = win;
    end
    if (win != m_owner || !others) m_hold = 0;
    else if (m_hold < MH) m_hold++;
    if (hready) begin
      if (htrans == T_NSEQ) m_beats = burst_len(hburst) - 1;
      else if (htrans == T_SEQ && m_beats > 0) m_beats--;
      if (lock) m_state = 3;
      else if (m_beats != 0) m_state = 2;
      else if (req != '0) m_state = 1;
      else m_state = 0;
    end
    m_owner = win;
  endtask

  // Apply one cycle of stimulus, queue what the DUT must show during it,
  // then step the model over the edge.
  task automatic drive(input logic [M-1:0] r, input logic [1:0] t, input logic [2:0] b,
                       input logic l, input logic rdy);
    exp_t e;
    req = r; htrans = t; hburst = b; lock = l; hready = rdy;
    e.gm = '0;
    e.gm[m_owner] = 1'b1;
    e.gi = 2'(m_owner);
    e.cs = m_can_switch();
    e.he = m_hold_exp();
    e.st = 2'(m_state);
    sb_q.push_back(e);
    @(posedge HCLK);
    model_edge();
    #1;
  endtask

  // Monitor: the DUT presents its outputs every cycle.
  always @(negedge HCLK) begin
    if (mon_en && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("sb_granted_master", 32'(granted_master), 32'(e.gm));
      check("sb_granted_idx",    32'(granted_idx),    32'(e.gi));
      check("sb_can_switch",     32'(can_switch),     32'(e.cs));
      check("sb_hold_expired",   32'(hold_expired),   32'(e.he));
      check("sb_arb_state",      32'(arb_state),      32'(e.st));
    end
  end

  // Asynchronous reset pulse taken in the middle of a cycle.
  task automatic pulse_reset(input string tag);
    mon_en = 1'b0;
    #1 HRESETn = 1'b0;
    #1;
    check({tag, "_granted_master"}, 32'(granted_master), 32'h1);
    check({tag, "_granted_idx"},    32'(granted_idx),    32'h0);
    check({tag, "_arb_state"},      32'(arb_state),      32'h0);
    check({tag, "_hold_expired"},   32'(hold_expired),   32'h0);
    model_reset();
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [M-1:0] rr_tab [4];
    int lock_left;
    req = '0; prio = '0; htrans = T_IDLE; hburst = B_SINGLE; lock = 1'b0; hready = 1'b1;
    HRESETn = 1'b1;
    model_reset();

    // Reset state, visible while reset is still asserted
    #1 HRESETn = 1'b0;
    #1;
    check("rst_granted_master", 32'(granted_master), 32'h1);
    check("rst_granted_idx",    32'(granted_idx),    32'h0);
    check("rst_hold_expired",   32'(hold_expired),   32'h0);
    check("rst_arb_state",      32'(arb_state),      32'h0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    mon_en = 1'b1;

    // Equal-priority round-robin on IDLE transfers: 1,2,0,1
    rr_tab[0] = 3'b010; rr_tab[1] = 3'b100; rr_tab[2] = 3'b001; rr_tab[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, T_IDLE, B_SINGLE, 1'b0, 1'b1);
      check("rr_sequence", 32'(granted_master), 32'(rr_tab[i]));
    end

    // INCR8 by master 0 is not preempted by a higher-priority master 2
    drive(3'b001, T_IDLE, B_SINGLE, 1'b0, 1'b1);
    check("incr8_owner0", 32'(granted_master), 32'h1);
    drive(3'b001, T_NSEQ, B_INCR8, 1'b0, 1'b1);
    prio[2] = 3'd5;
    for (int i = 0; i < 6; i++) begin
      drive(3'b101, T_SEQ, B_INCR8, 1'b0, 1'b1);
      check("incr8_no_preempt", 32'(granted_master), 32'h1);
    end
    drive(3'b101, T_SEQ, B_INCR8, 1'b0, 1'b1);
    check("incr8_switch_last_beat", 32'(granted_master), 32'h4);
    prio[2] = 3'd0;

    // Locked owner: hold expires but no switch until the lock drops
    drive(3'b001, T_IDLE, B_SINGLE, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      drive(3'b011, (k == 1) ? T_NSEQ : T_SEQ, B_INCR, 1'b1, 1'b1);
      check("lock_hold_expired", 32'(hold_expired), (k >= MH) ? 32'h1 : 32'h0);
      check("lock_no_switch", 32'(granted_master), 32'h1);
    end
    drive(3'b011, T_IDLE, B_INCR, 1'b0, 1'b1);
    check("lock_release_switch", 32'(granted_master), 32'h2);

    // Undefined INCR: fairness release, deferred past BUSY
    drive(3'b001, T_IDLE, B_SINGLE, 1'b0, 1'b1);
    drive(3'b011, T_NSEQ, B_INCR, 1'b0, 1'b1);
    drive(3'b011, T_SEQ, B_INCR, 1'b0, 1'b1);
    check("incr_hold_not_yet", 32'(hold_expired), 32'h0);
    drive(3'b011, T_SEQ, B_INCR, 1'b0, 1'b1);
    drive(3'b011, T_SEQ, B_INCR, 1'b0, 1'b1);
    check("incr_hold_expired", 32'(hold_expired), 32'h1);
    drive(3'b011, T_BUSY, B_INCR, 1'b0, 1'b1);
    drive(3'b011, T_BUSY, B_INCR, 1'b0, 1'b1);
    check("incr_busy_no_switch", 32'(granted_master), 32'h1);
    drive(3'b011, T_SEQ, B_INCR, 1'b0, 1'b1);
    check("incr_fair_switch", 32'(granted_master), 32'h2);

    // Wait states at the last beat of an INCR4
    drive(3'b001, T_IDLE, B_SINGLE, 1'b0, 1'b1);
    drive(3'b001, T_NSEQ, B_INCR4, 1'b0, 1'b1);
    drive(3'b001, T_SEQ, B_INCR4, 1'b0, 1'b1);
    drive(3'b001, T_SEQ, B_INCR4, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(3'b011, T_SEQ, B_INCR4, 1'b0, 1'b0);
      check("wait_no_switch", 32'(granted_master), 32'h1);
    end
    drive(3'b011, T_SEQ, B_INCR4, 1'b0, 1'b1);
    check("wait_switch_on_ready", 32'(granted_master), 32'h2);

    // Reset in the middle of a WRAP16 owned by master 2
    drive(3'b100, T_IDLE, B_SINGLE, 1'b0, 1'b1);
    check("wrap16_owner2", 32'(granted_master), 32'h4);
    drive(3'b100, T_NSEQ, B_WRAP16, 1'b0, 1'b1);
    drive(3'b100, T_SEQ, B_WRAP16, 1'b0, 1'b1);
    pulse_reset("wrap16_rst");
    check("wrap16_rst_beats_cleared", 32'(can_switch), 32'h0);
    drive(3'b110, T_IDLE, B_SINGLE, 1'b0, 1'b1);
    check("post_rst_rr_from_reset", 32'(granted_master), 32'h2);

    // Randomized traffic against the model
    lock_left = 0;
    for (int n = 0; n < 2000; n++) begin
      logic [M-1:0] r;
      logic [1:0]   t;
      logic [2:0]   b;
      logic         rdy;
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < M; i++) prio[i] = 3'($urandom_range(0, 3));
      end
      if (lock_left > 0) lock_left--;
      else if ($urandom_range(0, 31) == 0) lock_left = int'($urandom_range(2, 10));
      r   = M'($urandom_range(0, 7));
      t   = 2'($urandom_range(0, 3));
      b   = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      drive(r, t, b, (lock_left > 0), rdy);
      if (n == 1000) pulse_reset("rand_rst");
    end

    @(negedge HCLK);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
